// File: rtl/dht_meas_sched_pkg.sv
// Shared types and constants for the DHT measurement scheduler.
// Holds the scheduler state encoding, display mode codes and the byte
// positions inside the 40-bit receiver frame.
package dht_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CHECK   = 3'd3,
        ST_FAIL    = 3'd4,
        ST_BACKOFF = 3'd5
    } state_t;

    localparam logic [1:0] MODE_TEMP = 2'b00;
    localparam logic [1:0] MODE_HUM  = 2'b01;
    localparam logic [1:0] MODE_AUTO = 2'b10;
    localparam logic [1:0] MODE_MAX  = 2'b11;

    // Frame layout: {H_int, H_frac, T_int, T_frac, checksum}
    localparam int H_INT_LSB  = 32;
    localparam int H_FRAC_LSB = 24;
    localparam int T_INT_LSB  = 16;
    localparam int T_FRAC_LSB = 8;
    localparam int CSUM_LSB   = 0;

    function automatic logic [7:0] frame_byte(input logic [39:0] frame, input int lsb);
        return frame[lsb +: 8];
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dht_meas_sched_if.sv
// Bus between the measurement scheduler, the DHT receiver and the display path.
// The master side is the scheduler; the slave side is the receiver/display.
interface dht_meas_sched_if;

    logic        start_o;
    logic [39:0] rx_data_i;
    logic        rx_ready_i;
    logic        rx_error_i;
    logic [7:0]  disp_int_o;
    logic [7:0]  disp_frac_o;
    logic        disp_sel_o;
    logic        disp_valid_o;
    logic        fault_o;
    logic [15:0] meas_cnt_o;

    modport master (
        output start_o,
        input  rx_data_i, rx_ready_i, rx_error_i,
        output disp_int_o, disp_frac_o, disp_sel_o, disp_valid_o, fault_o, meas_cnt_o
    );

    modport slave (
        input  start_o,
        output rx_data_i, rx_ready_i, rx_error_i,
        input  disp_int_o, disp_frac_o, disp_sel_o, disp_valid_o, fault_o, meas_cnt_o
    );

endinterface

// File: rtl/dht_meas_sched_checksum.sv
// Combinational DHT frame checksum: the low byte must equal the
// modulo-256 sum of the four data bytes.
module dht_checksum
    import dht_pkg::*;
(
    input  logic [39:0] frame,
    output logic        ok
);

    logic [7:0] sum;

    // Wrap-around byte sum compared against the transmitted checksum
    always_comb begin
        sum = frame_byte(frame, H_INT_LSB) + frame_byte(frame, H_FRAC_LSB)
            + frame_byte(frame, T_INT_LSB) + frame_byte(frame, T_FRAC_LSB);
        ok  = (sum == frame_byte(frame, CSUM_LSB));
    end

endmodule

// File: rtl/dht_meas_sched.sv
// DHT measurement scheduler and result holder.
// Issues periodic or button-requested start pulses, validates returned frames,
// retries with back-off, holds the last good reading and drives the display bytes.
// Optional macro DHT_MINMAX_EN: track maximum temperature, shown in mode 11.
module dht_meas_sched
    import dht_pkg::*;
#(
    parameter int PERIOD_CYC    = 500000000,
    parameter int TIMEOUT_CYC   = 1000000,
    parameter int RETRY_GAP_CYC = 200000000,
    parameter int MAX_RETRY     = 3,
    parameter int ROTATE_CYC    = 300000000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       button_i,
    input  logic [1:0] mode_i,
    dht_meas_sched_if.master bus
);

    localparam int PW = cnt_width(PERIOD_CYC);
    localparam int TW = cnt_width(TIMEOUT_CYC);
    localparam int GW = cnt_width(RETRY_GAP_CYC);
    localparam int RW = cnt_width(MAX_RETRY + 1);
    localparam int OW = cnt_width(ROTATE_CYC);

    localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(RETRY_GAP_CYC - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
    localparam logic [OW-1:0] ROT_LAST  = OW'(ROTATE_CYC - 1);

    state_t          state, state_n;
    logic [PW-1:0]   per_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [RW-1:0]   retry_cnt;
    logic [OW-1:0]   rot_cnt;
    logic            rot_sel;
    logic            btn_q;
    logic            req_pend;
    logic [39:0]     frame_q;
    logic            csum_ok;
    logic [7:0]      h_int, h_frac, t_int, t_frac;
    logic            valid_q, fault_q;
    logic [15:0]     meas_q;
    logic [7:0]      disp_int_q, disp_frac_q;
    logic            disp_sel_q;
    logic [7:0]      show_int, show_frac;
    logic            show_sel;
    logic            is_auto;
    logic            tick, btn_edge;
    logic            start, take_req, latch_frame, good_frame, fail_final, retry_inc;
`ifdef DHT_MINMAX_EN
    logic [15:0]     max_t;
`endif

    assign tick     = (per_cnt == PER_LAST);
    assign btn_edge = button_i & ~btn_q;

`ifdef DHT_MINMAX_EN
    assign is_auto = (mode_i == MODE_AUTO);
`else
    assign is_auto = (mode_i == MODE_AUTO) || (mode_i == MODE_MAX);
`endif

    dht_checksum u_checksum (
        .frame (frame_q),
        .ok    (csum_ok)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_n;
    end

    // Next-state decode and one-cycle control strobes
    always_comb begin
        state_n     = state;
        start       = 1'b0;
        take_req    = 1'b0;
        latch_frame = 1'b0;
        good_frame  = 1'b0;
        fail_final  = 1'b0;
        retry_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_pend) begin
                    take_req = 1'b1;
                    state_n  = ST_TRIG;
                end
            end
            ST_TRIG: begin
                start   = 1'b1;
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.rx_error_i || (tmo_cnt == TMO_LAST)) begin
                    state_n = ST_FAIL;
                end else if (bus.rx_ready_i) begin
                    latch_frame = 1'b1;
                    state_n     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (csum_ok) begin
                    good_frame = 1'b1;
                    state_n    = ST_IDLE;
                end else begin
                    state_n = ST_FAIL;
                end
            end
            ST_FAIL: begin
                if (retry_cnt < RETRY_LIM) begin
                    retry_inc = 1'b1;
                    state_n   = ST_BACKOFF;
                end else begin
                    fail_final = 1'b1;
                    state_n    = ST_IDLE;
                end
            end
            ST_BACKOFF: begin
                if (gap_cnt == GAP_LAST) state_n = ST_TRIG;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Measurement requests: free-running period tick and button edge, coalesced
    always_ff @(posedge clk) begin
        if (!rst) begin
            per_cnt  <= '0;
            btn_q    <= 1'b0;
            req_pend <= 1'b0;
        end else begin
            per_cnt  <= tick ? '0 : per_cnt + PW'(1);
            btn_q    <= button_i;
            if (tick || btn_edge) req_pend <= 1'b1;
            else if (take_req)    req_pend <= 1'b0;
        end
    end

    // Attempt bookkeeping: response timeout, back-off gap, retry count, frame capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            retry_cnt <= '0;
            frame_q   <= '0;
        end else begin
            if (state == ST_TRIG)      tmo_cnt <= '0;
            else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + TW'(1);
            if (retry_inc)                gap_cnt <= '0;
            else if (state == ST_BACKOFF) gap_cnt <= gap_cnt + GW'(1);
            if (take_req)       retry_cnt <= '0;
            else if (retry_inc) retry_cnt <= retry_cnt + RW'(1);
            if (latch_frame) frame_q <= bus.rx_data_i;
        end
    end

    // Result holder: last good reading, validity, fault flag and good-frame count
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_int   <= '0;
            h_frac  <= '0;
            t_int   <= '0;
            t_frac  <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            meas_q  <= '0;
`ifdef DHT_MINMAX_EN
            max_t   <= '0;
`endif
        end else begin
            if (good_frame) begin
                h_int   <= frame_byte(frame_q, H_INT_LSB);
                h_frac  <= frame_byte(frame_q, H_FRAC_LSB);
                t_int   <= frame_byte(frame_q, T_INT_LSB);
                t_frac  <= frame_byte(frame_q, T_FRAC_LSB);
                valid_q <= 1'b1;
                fault_q <= 1'b0;
                meas_q  <= meas_q + 16'd1;
`ifdef DHT_MINMAX_EN
                if (!valid_q || ({frame_byte(frame_q, T_INT_LSB), frame_byte(frame_q, T_FRAC_LSB)} > max_t))
                    max_t <= {frame_byte(frame_q, T_INT_LSB), frame_byte(frame_q, T_FRAC_LSB)};
`endif
            end else if (fail_final) begin
                fault_q <= 1'b1;
            end
        end
    end

    // Auto-rotate dwell timer, restarted on temperature whenever auto mode is left
    always_ff @(posedge clk) begin
        if (!rst || !is_auto) begin
            rot_cnt <= '0;
            rot_sel <= 1'b0;
        end else if (rot_cnt == ROT_LAST) begin
            rot_cnt <= '0;
            rot_sel <= ~rot_sel;
        end else begin
            rot_cnt <= rot_cnt + OW'(1);
        end
    end

    // Channel selection for the display from mode and held data
    always_comb begin
        show_sel  = 1'b0;
        show_int  = t_int;
        show_frac = t_frac;
        if (is_auto) begin
            show_sel  = rot_sel;
            show_int  = rot_sel ? h_int  : t_int;
            show_frac = rot_sel ? h_frac : t_frac;
        end else if (mode_i == MODE_HUM) begin
            show_sel  = 1'b1;
            show_int  = h_int;
            show_frac = h_frac;
        end
`ifdef DHT_MINMAX_EN
        else if (mode_i == MODE_MAX) begin
            show_int  = max_t[15:8];
            show_frac = max_t[7:0];
        end
`endif
    end

    // Registered display outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_int_q  <= '0;
            disp_frac_q <= '0;
            disp_sel_q  <= 1'b0;
        end else begin
            disp_int_q  <= show_int;
            disp_frac_q <= show_frac;
            disp_sel_q  <= show_sel;
        end
    end

    assign bus.start_o      = start;
    assign bus.disp_int_o   = disp_int_q;
    assign bus.disp_frac_o  = disp_frac_q;
    assign bus.disp_sel_o   = disp_sel_q;
    assign bus.disp_valid_o = valid_q;
    assign bus.fault_o      = fault_q;
    assign bus.meas_cnt_o   = meas_q;

endmodule

// File: tb/tb_dht_meas_sched.sv
// Self-checking bench for dht_meas_sched with a behavioural result model.
// Build with DHT_MINMAX_EN defined to exercise the maximum-temperature view.
module tb_dht_meas_sched;

    localparam int PERIOD = 5000;
    localparam int TMO    = 50;
    localparam int GAP    = 100;
    localparam int MAXR   = 3;
    localparam int ROT    = 20;

    localparam logic [39:0] F_GOOD = 40'h3C_00_19_05_5A;
    localparam logic [39:0] F_BAD  = 40'h3C_00_19_05_00;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       button_i = 1'b0;
    logic [1:0] mode_i = 2'b00;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int start_times[$];

    dht_meas_sched_if bus();

    dht_meas_sched #(
        .PERIOD_CYC    (PERIOD),
        .TIMEOUT_CYC   (TMO),
        .RETRY_GAP_CYC (GAP),
        .MAX_RETRY     (MAXR),
        .ROTATE_CYC    (ROT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .button_i (button_i),
        .mode_i   (mode_i),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Record the cycle index of every start pulse
    always @(negedge clk) begin
        cyc++;
        if (bus.start_o === 1'b1) start_times.push_back(cyc);
    end

    function automatic logic [39:0] make_frame(input logic [7:0] hi, hf, ti, tf);
        logic [7:0] s;
        s = hi + hf + ti + tf;
        return {hi, hf, ti, tf, s};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        button_i = 1'b0;
        mode_i = 2'b00;
        bus.rx_data_i = '0;
        bus.rx_ready_i = 1'b0;
        bus.rx_error_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic press();
        button_i = 1'b1;
        @(negedge clk);
        button_i = 1'b0;
    endtask

    task automatic wait_start(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.start_o === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL %s: start_o got 0 required 1 within %0d cycles", name, budget);
        end
    endtask

    task automatic respond(input logic [39:0] frame, input bit err, input bit rdy, input int delay);
        repeat (delay) @(negedge clk);
        bus.rx_data_i  = frame;
        bus.rx_ready_i = rdy;
        bus.rx_error_i = err;
        @(negedge clk);
        bus.rx_ready_i = 1'b0;
        bus.rx_error_i = 1'b0;
    endtask

    task automatic measure(input logic [39:0] frame);
        press();
        wait_start(5, "measure_start");
        respond(frame, 1'b0, 1'b1, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests_run++;
        if ({bus.start_o, bus.disp_sel_o, bus.disp_int_o, bus.disp_frac_o,
             bus.disp_valid_o, bus.fault_o, bus.meas_cnt_o} !== 36'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got sel=%b int=%h frac=%h valid=%b fault=%b cnt=%0d required all 0",
                     bus.disp_sel_o, bus.disp_int_o, bus.disp_frac_o, bus.disp_valid_o, bus.fault_o, bus.meas_cnt_o);
        end
    endtask

    task automatic test_single();
        int base;
        do_reset();
        base = start_times.size();
        press();
        tests_run++;
        if (bus.start_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL start_early: got %b required 0", bus.start_o);
        end
        @(negedge clk);
        tests_run++;
        if (bus.start_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL start_latency: got %b required 1", bus.start_o);
        end
        respond(F_GOOD, 1'b0, 1'b1, 1);
        repeat (3) @(negedge clk);
        tests_run++;
        if ({bus.disp_sel_o, bus.disp_int_o, bus.disp_frac_o} !== {1'b0, 8'h19, 8'h05}) begin
            tests_failed++;
            $display("[TB] FAIL single_temp: got %b/%h/%h required 0/19/05", bus.disp_sel_o, bus.disp_int_o, bus.disp_frac_o);
        end
        tests_run++;
        if ({bus.disp_valid_o, bus.fault_o, bus.meas_cnt_o} !== {1'b1, 1'b0, 16'd1}) begin
            tests_failed++;
            $display("[TB] FAIL single_status: got valid=%b fault=%b cnt=%0d required 1/0/1", bus.disp_valid_o, bus.fault_o, bus.meas_cnt_o);
        end
        mode_i = 2'b01;
        @(negedge clk);
        tests_run++;
        if ({bus.disp_sel_o, bus.disp_int_o, bus.disp_frac_o} !== {1'b1, 8'h3C, 8'h00}) begin
            tests_failed++;
            $display("[TB] FAIL single_hum: got %b/%h/%h required 1/3c/00", bus.disp_sel_o, bus.disp_int_o, bus.disp_frac_o);
        end
        tests_run++;
        if (start_times.size() - base !== 1) begin
            tests_failed++;
            $display("[TB] FAIL single_start_count: got %0d required 1", start_times.size() - base);
        end
    endtask

    task automatic test_mid_reset();
        int base;
        do_reset();
        button_i = 1'b1;
        @(negedge clk);
        button_i = 1'b0;
        base = start_times.size();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.start_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_start: got %b required 0", bus.start_o);
        end
        rst = 1'b1;
        repeat (6) @(negedge clk);
        tests_run++;
        if (start_times.size() - base !== 0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_pending: got %0d starts required 0", start_times.size() - base);
        end
    endtask

    task automatic test_retry();
        int base;
        do_reset();
        measure(F_GOOD);
        base = start_times.size();
        press();
        wait_start(5, "retry_first");
        respond(F_BAD, 1'b0, 1'b1, 1);
        for (int k = 1; k <= MAXR; k++) begin
            wait_start(GAP + 20, "retry_next");
            if (k == MAXR) begin
                tests_run++;
                if (bus.fault_o !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL retry_early_fault: got %b required 0", bus.fault_o);
                end
            end
            respond(F_BAD, 1'b0, 1'b1, 1);
        end
        repeat (GAP + 30) @(negedge clk);
        tests_run++;
        if (start_times.size() - base !== MAXR + 1) begin
            tests_failed++;
            $display("[TB] FAIL retry_count: got %0d starts required %0d", start_times.size() - base, MAXR + 1);
        end
        // trig + one wait + check + fail + back-off gap
        for (int k = 0; k < MAXR && base + k + 1 < start_times.size(); k++) begin
            tests_run++;
            if (start_times[base + k + 1] - start_times[base + k] !== GAP + 4) begin
                tests_failed++;
                $display("[TB] FAIL retry_spacing: got %0d required %0d", start_times[base + k + 1] - start_times[base + k], GAP + 4);
            end
        end
        tests_run++;
        if ({bus.fault_o, bus.disp_valid_o, bus.meas_cnt_o, bus.disp_int_o, bus.disp_frac_o} !== {1'b1, 1'b1, 16'd1, 8'h19, 8'h05}) begin
            tests_failed++;
            $display("[TB] FAIL retry_final: got fault=%b valid=%b cnt=%0d int=%h frac=%h required 1/1/1/19/05",
                     bus.fault_o, bus.disp_valid_o, bus.meas_cnt_o, bus.disp_int_o, bus.disp_frac_o);
        end
    endtask

    task automatic test_timeout();
        int base;
        do_reset();
        base = start_times.size();
        press();
        wait_start(5, "timeout_first");
        for (int k = 1; k <= MAXR; k++) wait_start(GAP + TMO + 20, "timeout_next");
        repeat (GAP + TMO + 20) @(negedge clk);
        tests_run++;
        if (start_times.size() - base !== MAXR + 1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_count: got %0d starts required %0d", start_times.size() - base, MAXR + 1);
        end
        // trig + full timeout in wait + fail + back-off gap
        if (start_times.size() - base >= 2) begin
            tests_run++;
            if (start_times[base + 1] - start_times[base] !== GAP + TMO + 2) begin
                tests_failed++;
                $display("[TB] FAIL timeout_spacing: got %0d required %0d", start_times[base + 1] - start_times[base], GAP + TMO + 2);
            end
        end
        tests_run++;
        if ({bus.fault_o, bus.disp_valid_o, bus.meas_cnt_o} !== {1'b1, 1'b0, 16'd0}) begin
            tests_failed++;
            $display("[TB] FAIL timeout_fault: got fault=%b valid=%b cnt=%0d required 1/0/0", bus.fault_o, bus.disp_valid_o, bus.meas_cnt_o);
        end
        measure(F_GOOD);
        tests_run++;
        if ({bus.fault_o, bus.disp_valid_o, bus.meas_cnt_o} !== {1'b0, 1'b1, 16'd1}) begin
            tests_failed++;
            $display("[TB] FAIL timeout_recover: got fault=%b valid=%b cnt=%0d required 0/1/1", bus.fault_o, bus.disp_valid_o, bus.meas_cnt_o);
        end
    endtask

    task automatic test_coalesce();
        int base;
        do_reset();
        base = start_times.size();
        press();
        wait_start(5, "coalesce_first");
        press();
        @(negedge clk);
        press();
        @(negedge clk);
        respond(F_GOOD, 1'b0, 1'b1, 0);
        wait_start(20, "coalesce_second");
        respond(F_GOOD, 1'b0, 1'b1, 1);
        repeat (60) @(negedge clk);
        tests_run++;
        if ({start_times.size() - base, 32'(bus.meas_cnt_o)} !== {32'd2, 32'd2}) begin
            tests_failed++;
            $display("[TB] FAIL coalesce: got starts=%0d cnt=%0d required 2/2", start_times.size() - base, bus.meas_cnt_o);
        end
    endtask

    task automatic test_periodic();
        int first = -1;
        do_reset();
        for (int i = 1; i <= PERIOD + 10 && first < 0; i++) begin
            @(negedge clk);
            if (bus.start_o === 1'b1) first = i;
        end
        tests_run++;
        if (first !== PERIOD + 1) begin
            tests_failed++;
            $display("[TB] FAIL periodic_tick: got first start at %0d required %0d", first, PERIOD + 1);
        end
        respond(F_GOOD, 1'b0, 1'b1, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rotate();
        logic       exp_sel;
        logic [7:0] exp_int;
        int         errs = 0;
        do_reset();
        measure(F_GOOD);
        mode_i = 2'b01;
        @(negedge clk);
        mode_i = 2'b10;
        for (int j = 0; j < 4 * ROT; j++) begin
            @(negedge clk);
            exp_sel = ((j / ROT) % 2) == 1;
            exp_int = exp_sel ? 8'h3C : 8'h19;
            tests_run++;
            if ({bus.disp_sel_o, bus.disp_int_o} !== {exp_sel, exp_int}) begin
                tests_failed++;
                if (errs < 5) $display("[TB] FAIL rotate_step%0d: got %b/%h required %b/%h", j, bus.disp_sel_o, bus.disp_int_o, exp_sel, exp_int);
                errs++;
            end
        end
        mode_i = 2'b01;
        @(negedge clk);
        tests_run++;
        if (bus.disp_sel_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rotate_exit: got %b required 1", bus.disp_sel_o);
        end
    endtask

    task automatic test_minmax();
        do_reset();
        measure(make_frame(8'h30, 8'h01, 8'h19, 8'h05));
        measure(make_frame(8'h31, 8'h02, 8'h1B, 8'h00));
        measure(make_frame(8'h32, 8'h03, 8'h18, 8'h09));
        mode_i = 2'b11;
        @(negedge clk);
`ifdef DHT_MINMAX_EN
        tests_run++;
        if ({bus.disp_sel_o, bus.disp_int_o, bus.disp_frac_o} !== {1'b0, 8'h1B, 8'h00}) begin
            tests_failed++;
            $display("[TB] FAIL minmax_view: got %b/%h/%h required 0/1b/00", bus.disp_sel_o, bus.disp_int_o, bus.disp_frac_o);
        end
        mode_i = 2'b00;
        @(negedge clk);
        tests_run++;
        if ({bus.disp_int_o, bus.disp_frac_o} !== {8'h18, 8'h09}) begin
            tests_failed++;
            $display("[TB] FAIL minmax_latest: got %h/%h required 18/09", bus.disp_int_o, bus.disp_frac_o);
        end
`else
        tests_run++;
        if ({bus.disp_sel_o, bus.disp_int_o, bus.disp_frac_o} !== {1'b0, 8'h18, 8'h09}) begin
            tests_failed++;
            $display("[TB] FAIL mode11_rot_start: got %b/%h/%h required 0/18/09", bus.disp_sel_o, bus.disp_int_o, bus.disp_frac_o);
        end
        repeat (ROT) @(negedge clk);
        tests_run++;
        if ({bus.disp_sel_o, bus.disp_int_o, bus.disp_frac_o} !== {1'b1, 8'h32, 8'h03}) begin
            tests_failed++;
            $display("[TB] FAIL mode11_rot_hum: got %b/%h/%h required 1/32/03", bus.disp_sel_o, bus.disp_int_o, bus.disp_frac_o);
        end
`endif
    endtask

    task automatic test_random();
        logic [7:0]  m_hi = 0, m_hf = 0, m_ti = 0, m_tf = 0;
        logic        m_valid = 0, m_fault = 0;
        logic [15:0] m_cnt = 0;
        logic [7:0]  hi, hf, ti, tf;
        logic [39:0] fr;
        logic        exp_sel;
        do_reset();
        for (int it = 0; it < 6; it++) begin
            hi = 8'($urandom); hf = 8'($urandom); ti = 8'($urandom); tf = 8'($urandom);
            fr = make_frame(hi, hf, ti, tf);
            press();
            wait_start(5, "random_start");
            if ($urandom_range(0, 2) != 0) begin
                respond(fr, 1'b0, 1'b1, $urandom_range(1, 8));
                m_hi = hi; m_hf = hf; m_ti = ti; m_tf = tf;
                m_valid = 1'b1; m_fault = 1'b0; m_cnt++;
            end else begin
                for (int a = 0; a <= MAXR; a++) begin
                    if (a > 0) wait_start(GAP + 20, "random_retry");
                    case ($urandom_range(0, 2))
                        0:       respond(fr ^ 40'(1 + $urandom_range(0, 254)), 1'b0, 1'b1, $urandom_range(1, 8));
                        1:       respond(fr, 1'b1, 1'b0, $urandom_range(1, 8));
                        default: respond(fr, 1'b1, 1'b1, $urandom_range(1, 8));
                    endcase
                end
                m_fault = 1'b1;
            end
            repeat (6) @(negedge clk);
            mode_i = 2'($urandom_range(0, 1));
            exp_sel = mode_i[0];
            @(negedge clk);
            tests_run++;
            if ({bus.disp_sel_o, bus.disp_int_o, bus.disp_frac_o} !== {exp_sel, exp_sel ? m_hi : m_ti, exp_sel ? m_hf : m_tf}) begin
                tests_failed++;
                $display("[TB] FAIL random_view%0d: got %b/%h/%h required %b/%h/%h", it, bus.disp_sel_o, bus.disp_int_o,
                         bus.disp_frac_o, exp_sel, exp_sel ? m_hi : m_ti, exp_sel ? m_hf : m_tf);
            end
            tests_run++;
            if ({bus.disp_valid_o, bus.fault_o, bus.meas_cnt_o} !== {m_valid, m_fault, m_cnt}) begin
                tests_failed++;
                $display("[TB] FAIL random_status%0d: got %b/%b/%0d required %b/%b/%0d", it, bus.disp_valid_o, bus.fault_o,
                         bus.meas_cnt_o, m_valid, m_fault, m_cnt);
            end
        end
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        test_reset();
        test_single();
        test_mid_reset();
        test_retry();
        test_timeout();
        test_coalesce();
        test_periodic();
        test_rotate();
        test_minmax();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
